// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state codes, opcodes, mux selects.
// MC_CTRL_JAL_EN adds the JAL state code.
package mc_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
`ifdef MC_CTRL_JAL_EN
    S_JAL      = 4'd10,
`endif
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  localparam logic [SEL_W-1:0] MTR_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] MTR_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] MTR_PC     = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;

  typedef struct packed {
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic [SEL_W-1:0] mem_to_reg;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_src;
    logic             err;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // States that wait on the memory handshake and are subject to the timeout
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_timeout_counter.sv
// Counts memory wait cycles; expired flags the wait cycle that would reach the limit.
// A limit of 0 never expires.
module mc_timeout_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam int unsigned EXT_W = CNT_W + 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Extended compare so count+1 cannot wrap onto the limit
  assign expired = enable && (limit != '0) &&
                   ((EXT_W'(count_q) + EXT_W'(1)) == EXT_W'(limit));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM (Moore) with memory-wait timeout and sticky error.
// Define MC_CTRL_JAL_EN to decode JAL; otherwise it is treated as an illegal opcode.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic [SEL_W-1:0] mem_to_reg,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] alu_op,
  output logic [SEL_W-1:0] pc_src,
  output logic [STATE_W-1:0] state,
  output logic             err
);

  state_t state_q, state_d;
  logic   active_q;
  ctrl_t  ctrl, ctrl_out;
  logic   mem_wait, tmo_clear, tmo_en, tmo_expired;

  // active_q holds outputs at zero until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (active_q) begin
        state_q <= state_d;
      end
    end
  end

  assign mem_wait  = active_q && is_mem_wait(state_q);
  assign tmo_en    = mem_wait && !mem_ready;
  assign tmo_clear = !mem_wait || mem_ready;

  mc_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .limit   (CNT_W'(MEM_TIMEOUT)),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_R:               state_d = S_EXEC_R;
          OPC_I:               state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
`ifdef MC_CTRL_JAL_EN
          OPC_JAL:             state_d = S_JAL;
`endif
          default:             state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo_expired) begin
          state_d = S_ERROR;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MTR_MDR;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_expired) begin
          state_d = S_ERROR;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MTR_ALUOUT;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_BRANCH;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = zero;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MTR_PC;
        state_d = S_FETCH;
      end
`endif
      S_ERROR: begin
        ctrl.err = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign ctrl_out = active_q ? ctrl : CTRL_IDLE;

  assign pc_write   = ctrl_out.pc_write;
  assign ir_write   = ctrl_out.ir_write;
  assign reg_write  = ctrl_out.reg_write;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign iord       = ctrl_out.iord;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_src     = ctrl_out.pc_src;
  assign err        = ctrl_out.err;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instruction sequences, memory waits, timeout, reset abort.
// Honours MC_CTRL_JAL_EN for the JAL expectations.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MADDR = 4'd2,
                         ST_MRD = 4'd3, ST_MWB = 4'd4, ST_MWR = 4'd5,
                         ST_EXR = 4'd6, ST_AWB = 4'd8, ST_BR = 4'd9,
                         ST_JAL = 4'd10, ST_ERR = 4'd15;

  mc_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released just after an edge; outputs stay zero until the next edge
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #3;
    check_eq("rst_state", 32'(state), 32'(ST_FETCH));
    check_eq("rst_mem_read", 32'(mem_read), 0);
    check_eq("rst_err", 32'(err), 0);

    // R-type, zero-wait
    do_reset();
    check_eq("pre_active_mem_read", 32'(mem_read), 0);
    cycle();
    opcode = 7'b0110011;
    #1;
    check_eq("r_fetch_state", 32'(state), 32'(ST_FETCH));
    check_eq("r_fetch_mem_read", 32'(mem_read), 1);
    check_eq("r_fetch_ir_write", 32'(ir_write), 1);
    check_eq("r_fetch_pc_write", 32'(pc_write), 1);
    check_eq("r_fetch_src_b", 32'(alu_src_b), 1);
    cycle();
    check_eq("r_dec_state", 32'(state), 32'(ST_DECODE));
    check_eq("r_dec_src_a", 32'(alu_src_a), 2);
    check_eq("r_dec_src_b", 32'(alu_src_b), 2);
    check_eq("r_dec_reg_write", 32'(reg_write), 0);
    cycle();
    check_eq("r_ex_state", 32'(state), 32'(ST_EXR));
    check_eq("r_ex_alu_op", 32'(alu_op), 2);
    check_eq("r_ex_src_a", 32'(alu_src_a), 1);
    check_eq("r_ex_src_b", 32'(alu_src_b), 0);
    check_eq("r_ex_reg_write", 32'(reg_write), 0);
    cycle();
    check_eq("r_wb_state", 32'(state), 32'(ST_AWB));
    check_eq("r_wb_reg_write", 32'(reg_write), 1);
    check_eq("r_wb_mem_to_reg", 32'(mem_to_reg), 0);
    cycle();
    check_eq("r_next_state", 32'(state), 32'(ST_FETCH));
    check_eq("r_next_reg_write", 32'(reg_write), 0);

    // Load with 3 wait cycles in MEM_RD
    opcode = 7'b0000011;
    cycle();
    check_eq("ld_dec_state", 32'(state), 32'(ST_DECODE));
    cycle();
    check_eq("ld_addr_state", 32'(state), 32'(ST_MADDR));
    check_eq("ld_addr_src_a", 32'(alu_src_a), 1);
    check_eq("ld_addr_src_b", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      check_eq("ld_wait_state", 32'(state), 32'(ST_MRD));
      check_eq("ld_wait_mem_read", 32'(mem_read), 1);
      check_eq("ld_wait_iord", 32'(iord), 1);
      cycle();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("ld_rd4_state", 32'(state), 32'(ST_MRD));
    cycle();
    check_eq("ld_wb_state", 32'(state), 32'(ST_MWB));
    check_eq("ld_wb_reg_write", 32'(reg_write), 1);
    check_eq("ld_wb_mem_to_reg", 32'(mem_to_reg), 1);
    check_eq("ld_wb_mem_read", 32'(mem_read), 0);
    cycle();
    check_eq("ld_next_state", 32'(state), 32'(ST_FETCH));

    // Branch taken then not taken
    opcode = 7'b1100011;
    zero   = 1'b1;
    cycle();
    cycle();
    check_eq("br1_state", 32'(state), 32'(ST_BR));
    check_eq("br1_pc_write", 32'(pc_write), 1);
    check_eq("br1_pc_src", 32'(pc_src), 1);
    check_eq("br1_alu_op", 32'(alu_op), 1);
    cycle();
    check_eq("br1_next_state", 32'(state), 32'(ST_FETCH));
    zero = 1'b0;
    cycle();
    cycle();
    check_eq("br0_state", 32'(state), 32'(ST_BR));
    check_eq("br0_pc_write", 32'(pc_write), 0);
    cycle();

    // Store, reset pulsed while waiting in MEM_WR
    opcode = 7'b0100011;
    cycle();
    cycle();
    check_eq("st_addr_state", 32'(state), 32'(ST_MADDR));
    mem_ready = 1'b0;
    cycle();
    check_eq("st_wr_state", 32'(state), 32'(ST_MWR));
    check_eq("st_wr_mem_write", 32'(mem_write), 1);
    check_eq("st_wr_iord", 32'(iord), 1);
    rst_n = 1'b0;
    #1;
    check_eq("st_abort_mem_write", 32'(mem_write), 0);
    check_eq("st_abort_state", 32'(state), 32'(ST_FETCH));
    do_reset();
    mem_ready = 1'b0;
    cycle();

    // Timeout in FETCH after 15 wait cycles
    check_eq("st_after_rst_mem_read", 32'(mem_read), 1);
    for (int i = 1; i <= 15; i++) begin
      check_eq("tmo_wait_state", 32'(state), 32'(ST_FETCH));
      check_eq("tmo_wait_ir_write", 32'(ir_write), 0);
      cycle();
    end
    check_eq("tmo_err_state", 32'(state), 32'(ST_ERR));
    check_eq("tmo_err_flag", 32'(err), 1);
    check_eq("tmo_err_mem_read", 32'(mem_read), 0);
    mem_ready = 1'b1;
    cycle();
    cycle();
    check_eq("tmo_sticky_state", 32'(state), 32'(ST_ERR));
    check_eq("tmo_sticky_err", 32'(err), 1);
    check_eq("tmo_sticky_ir_write", 32'(ir_write), 0);
    rst_n = 1'b0;
    #1;
    check_eq("tmo_rst_err", 32'(err), 0);

    // mem_ready on the 15th wait cycle wins over the timeout
    do_reset();
    mem_ready = 1'b0;
    opcode    = 7'b0000000;
    cycle();
    for (int i = 1; i <= 14; i++) cycle();
    mem_ready = 1'b1;
    #1;
    check_eq("win_c15_state", 32'(state), 32'(ST_FETCH));
    check_eq("win_c15_ir_write", 32'(ir_write), 1);
    cycle();
    check_eq("win_dec_state", 32'(state), 32'(ST_DECODE));
    cycle();
    check_eq("illegal_state", 32'(state), 32'(ST_ERR));
    check_eq("illegal_err", 32'(err), 1);

    // JAL opcode
    do_reset();
    opcode = 7'b1101111;
    cycle();
    cycle();
    check_eq("jal_dec_state", 32'(state), 32'(ST_DECODE));
    cycle();
`ifdef MC_CTRL_JAL_EN
    check_eq("jal_state", 32'(state), 32'(ST_JAL));
    check_eq("jal_pc_write", 32'(pc_write), 1);
    check_eq("jal_pc_src", 32'(pc_src), 1);
    check_eq("jal_reg_write", 32'(reg_write), 1);
    check_eq("jal_mem_to_reg", 32'(mem_to_reg), 2);
    cycle();
    check_eq("jal_next_state", 32'(state), 32'(ST_FETCH));
`else
    check_eq("jal_off_state", 32'(state), 32'(ST_ERR));
    check_eq("jal_off_err", 32'(err), 1);
    check_eq("jal_off_pc_write", 32'(pc_write), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
